// File: rtl/itcm_pkg.sv
// Constants and the response entry type shared by the ITCM fetch-path responder.
package itcm_pkg;

  localparam int ITCM_DATA_W = 32;
  localparam int ITCM_RAM_AW = 12;
  localparam logic [31:0] ITCM_BASE_ADDR = 32'h8000_0000;
  localparam logic [ITCM_DATA_W-1:0] ITCM_ERR_DATA = '0;

  typedef struct packed {
    logic                   err;
    logic [ITCM_DATA_W-1:0] rdata;
  } itcm_rsp_t;

endpackage

// File: rtl/itcm_rsp_fifo.sv
// Small in-order response FIFO with flop storage; push and pop may coincide,
// including on a full FIFO.
module itcm_rsp_fifo
  import itcm_pkg::*;
#(
  parameter int WIDTH = $bits(itcm_rsp_t),
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] wen;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
    assign wen[gi] = do_push && (wr_ptr_q == PW'(gi));
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) mem_q[i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/itcm_icb_resp.sv
// ICB slave for instruction fetch in front of a 1-cycle SRAM: range/alignment check,
// outstanding tracking and in-order buffered responses. Option macro: ITCM_RSP_BYPASS_EN.
module itcm_icb_resp
  import itcm_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = ITCM_DATA_W,
  parameter int                RAM_AW     = ITCM_RAM_AW,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(ITCM_BASE_ADDR),
  parameter int                OUTS_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [DATA_W-1:0] icb_rsp_rdata,
  output logic              ram_cs,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              itcm_active
);

  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(OUTS_DEPTH);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s1_vld_q, s1_vld_d, s1_err_q, s1_err_d;
  logic              addr_hit, addr_aligned, cmd_err, cmd_hs, rsp_hs;
  logic              rsp_vld_raw, rsp_err_raw;
  logic [DATA_W-1:0] rsp_data_raw, s1_data;
  logic              fifo_push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  // rst_n is active-high despite its name; every output is forced idle while it is set.
  assign addr_hit      = icb_cmd_addr[ADDR_W-1:RAM_AW+2] == BASE_ADDR[ADDR_W-1:RAM_AW+2];
  assign addr_aligned  = (icb_cmd_addr[1:0] == 2'b00);
  assign cmd_err       = !(addr_hit && addr_aligned);
  assign rsp_hs        = icb_rsp_valid & icb_rsp_ready;
  assign icb_cmd_ready = !rst_n & ((cnt_q < DEPTH_C) | rsp_hs);
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
  assign ram_cs        = cmd_hs & !cmd_err;
  assign ram_addr      = icb_cmd_addr[RAM_AW+1:2];
  assign itcm_active   = !rst_n & (icb_cmd_valid | (cnt_q != '0));
  assign s1_data       = s1_err_q ? DATA_W'(ITCM_ERR_DATA) : ram_rdata;

`ifdef ITCM_RSP_BYPASS_EN
  logic bypass_sel;
  assign bypass_sel    = fifo_empty & s1_vld_q;
  assign rsp_vld_raw   = !fifo_empty | s1_vld_q;
  assign rsp_err_raw   = bypass_sel ? s1_err_q : fifo_rdata[DATA_W];
  assign rsp_data_raw  = bypass_sel ? s1_data : fifo_rdata[DATA_W-1:0];
  assign fifo_push_req = s1_vld_q & !(bypass_sel & rsp_hs);
  assign fifo_pop      = rsp_hs & !fifo_empty;
`else
  assign rsp_vld_raw   = !fifo_empty;
  assign rsp_err_raw   = fifo_rdata[DATA_W];
  assign rsp_data_raw  = fifo_rdata[DATA_W-1:0];
  assign fifo_push_req = s1_vld_q;
  assign fifo_pop      = rsp_hs;
`endif

  // The cnt bound already rules out a push into a full FIFO without a pop.
  assign fifo_push     = fifo_push_req & (!fifo_full | fifo_pop);
  assign icb_rsp_valid = !rst_n & rsp_vld_raw;
  assign icb_rsp_err   = icb_rsp_valid & rsp_err_raw;
  assign icb_rsp_rdata = icb_rsp_valid ? rsp_data_raw : '0;

  always_comb begin
    cnt_d    = cnt_q;
    s1_vld_d = cmd_hs;
    s1_err_d = cmd_hs & cmd_err;
    case ({cmd_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      s1_vld_q <= s1_vld_d;
      s1_err_q <= s1_err_d;
    end
  end

  itcm_rsp_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OUTS_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst_i  (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({s1_err_q, s1_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_itcm_icb_resp.sv
// Directed and randomized-backpressure bench for itcm_icb_resp with an in-order scoreboard.
module tb_itcm_icb_resp;

`ifdef ITCM_RSP_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        icb_cmd_valid = 1'b0;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr = '0;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready = 1'b0;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        ram_cs;
  logic [11:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        itcm_active;

  itcm_icb_resp dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata),
    .ram_cs        (ram_cs),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata),
    .itcm_active   (itcm_active)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM model, 1-cycle read latency.
  logic [31:0] mem [4096];
  always @(posedge clk) if (ram_cs) ram_rdata <= mem[ram_addr];

  int checks = 0, passes = 0, fails = 0;
  int issued = 0, received = 0;
  bit verbose = 1'b1;
  logic last_cmd_hs = 1'b0;
  logic hold_q = 1'b0, hold_err = 1'b0;
  logic [31:0] hold_data = '0;
  logic [32:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic m_err(input logic [31:0] a);
    return !((a[31:14] == 18'h20000) && (a[1:0] == 2'b00));
  endfunction

  // Drive one cycle of inputs, then sample and score this cycle's handshakes.
  task automatic drive(input logic v, input logic [31:0] a, input logic r,
                       input logic e_err, input logic [31:0] e_data);
    logic [32:0] e;
    icb_cmd_valid = v;
    icb_cmd_addr  = a;
    icb_rsp_ready = r;
    #1;
    if (!rst_n) begin
      if (hold_q) begin
        chk("rsp_hold_valid", icb_rsp_valid, 1);
        chk("rsp_hold_err", icb_rsp_err, hold_err);
        chk("rsp_hold_rdata", icb_rsp_rdata, hold_data);
      end
      if (icb_rsp_valid && icb_rsp_ready) begin
        received++;
        chk("rsp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_err", icb_rsp_err, e[32]);
          chk("rsp_rdata", icb_rsp_rdata, e[31:0]);
          if (verbose) $display("rsp %0d: err=%0b rdata=%h", received, icb_rsp_err, icb_rsp_rdata);
        end
      end
      hold_q    = icb_rsp_valid && !icb_rsp_ready;
      hold_err  = icb_rsp_err;
      hold_data = icb_rsp_rdata;
      chk("cnt_bound", dut.cnt_q <= DEPTH, 1);
      chk("fifo_overflow", dut.fifo_push_req & dut.fifo_full & !dut.fifo_pop, 0);
    end else begin
      hold_q = 1'b0;
    end
    last_cmd_hs = v && icb_cmd_ready;
    if (last_cmd_hs) begin
      issued++;
      exp_q.push_back({e_err, e_data});
      if (verbose) $display("cmd %0d: addr=%h", issued, a);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int cycles;
    int base;
    bit pending;
    logic [31:0] cur_addr;
    logic [11:0] w;

    for (int i = 0; i < 4096; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[4] = 32'hDEAD_BEEF;

    // Reset state
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_cmd_ready", icb_cmd_ready, 0);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_rsp_err", icb_rsp_err, 0);
    chk("rst_rsp_rdata", icb_rsp_rdata, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_itcm_active", itcm_active, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    rst_n = 1'b0;

    // Single fetch
    drive(1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("single_cmd_ready", icb_cmd_ready, 1);
    chk("single_ram_cs", ram_cs, 1);
    chk("single_ram_addr", ram_addr, 4);
    chk("single_active", itcm_active, 1);
    tick();
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      if (icb_rsp_valid) begin
        lat = k;
        chk("single_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
        chk("single_err", icb_rsp_err, 0);
        tick();
        break;
      end
      tick();
    end
    chk("single_latency", lat, LAT);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("idle_rsp_valid", icb_rsp_valid, 0);
    chk("idle_rsp_rdata", icb_rsp_rdata, 0);
    chk("idle_active", itcm_active, 0);
    tick();

    // Out-of-range and misaligned commands
    drive(1'b1, 32'h9000_0000, 1'b1, 1'b1, 32'h0);
    chk("oor_cmd_ready", icb_cmd_ready, 1);
    chk("oor_ram_cs", ram_cs, 0);
    tick();
    drive(1'b1, 32'h8000_0002, 1'b1, 1'b1, 32'h0);
    chk("misal_cmd_ready", icb_cmd_ready, 1);
    chk("misal_ram_cs", ram_cs, 0);
    tick();
    drain("err_drain");

    // Backpressure
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'hC0DE_0000);
    chk("bp_cmd0_ready", icb_cmd_ready, 1);
    tick();
    drive(1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'hC0DE_0001);
    chk("bp_cmd1_ready", icb_cmd_ready, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'hC0DE_0002);
      chk("bp_cmd2_blocked", icb_cmd_ready, 0);
      tick();
    end
    drive(1'b1, 32'h8000_0008, 1'b1, 1'b0, 32'hC0DE_0002);
    chk("bp_head_valid", icb_rsp_valid, 1);
    chk("bp_head_rdata", icb_rsp_rdata, 32'hC0DE_0000);
    chk("bp_cmd2_accept", icb_cmd_ready, 1);
    tick();
    drain("bp_drain");

    // Streaming
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b1, 1'b0,
            (i == 4) ? 32'hDEAD_BEEF : {16'hC0DE, 16'(i)});
      chk("stream_cmd_ready", icb_cmd_ready, 1);
      if (i >= LAT) chk("stream_rsp_valid", icb_rsp_valid, 1);
      tick();
    end
    drain("stream_drain");

    // Reset with two requests in flight
    drive(1'b1, 32'h8000_0020, 1'b0, 1'b0, 32'hC0DE_0008);
    tick();
    drive(1'b1, 32'h8000_0024, 1'b0, 1'b0, 32'hC0DE_0009);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("midrst_rsp_valid", icb_rsp_valid, 0);
    chk("midrst_cmd_ready", icb_cmd_ready, 0);
    tick();
    exp_q.delete();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("postrst_active", itcm_active, 0);
    chk("postrst_rsp_valid", icb_rsp_valid, 0);
    tick();
    drive(1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("postrst_cmd_ready", icb_cmd_ready, 1);
    tick();
    drain("postrst_drain");

    // Random rsp_ready with mixed good and errored addresses
    verbose = 1'b0;
    base = issued;
    cycles = 0;
    pending = 1'b0;
    cur_addr = '0;
    while ((issued - base) < 1000 && cycles < 20000) begin
      if (!pending) begin
        w = 12'($urandom_range(0, 4095));
        case ($urandom_range(0, 3))
          0, 1:    cur_addr = 32'h8000_0000 | {18'b0, w, 2'b00};
          2:       cur_addr = (($urandom_range(0, 1) != 0) ? 32'h8000_4000 : 32'h9000_0000)
                              | {18'b0, w, 2'b00};
          default: cur_addr = 32'h8000_0000 | {18'b0, w, 2'(($urandom_range(1, 3)))};
        endcase
        pending = 1'b1;
      end
      drive(1'b1, cur_addr, 1'($urandom_range(0, 1)), m_err(cur_addr),
            m_err(cur_addr) ? 32'h0 : mem[cur_addr[13:2]]);
      if (last_cmd_hs) pending = 1'b0;
      tick();
      cycles++;
    end
    chk("rand_issued", issued - base, 1000);
    drain("rand_drain");
    chk("total_in_order", received, issued - 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
